// File: rtl/mips_pkg.sv
// Shared types and default widths for the memory-side blocks of the MIPS core.
package mips_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and the data stage.
// Data wins ties, but fetch is guaranteed a grant after STARVE_MAX data grants.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic [DATA_W-1:0] iRdata,
  output logic              iReady,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic [DATA_W-1:0] dRdata,
  output logic              dReady,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memAck,
  output logic              StallMF,
  output logic              StallMM
);

  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  arb_state_t        r_state, w_state_next;
  logic [CntW-1:0]   r_starve_cnt, w_starve_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_irdata;
  logic [DATA_W-1:0] r_drdata;
  logic              w_grant_i, w_grant_d;
  logic              w_done_i, w_done_d;

  always_comb begin
    w_state_next  = r_state;
    w_starve_next = r_starve_cnt;
    w_grant_i     = 1'b0;
    w_grant_d     = 1'b0;
    w_done_i      = 1'b0;
    w_done_d      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (dReq && (!iReq || (r_starve_cnt < CntMax))) begin
          w_grant_d    = 1'b1;
          w_state_next = DACC;
          // Only count data grants that actually made fetch wait.
          if (iReq && (r_starve_cnt != CntMax)) begin
            w_starve_next = r_starve_cnt + CntW'(1);
          end
        end else if (iReq) begin
          w_grant_i     = 1'b1;
          w_state_next  = IACC;
          w_starve_next = '0;
        end
      end
      IACC: begin
        if (memAck) begin
          w_done_i     = 1'b1;
          w_state_next = IDLE;
        end
      end
      DACC: begin
        if (memAck) begin
          w_done_d     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_irdata     <= '0;
      r_drdata     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
      if (w_grant_d) begin
        r_addr  <= dAddr;
        r_we    <= dWe;
        r_wdata <= dWdata;
      end else if (w_grant_i) begin
        r_addr <= iAddr;
        r_we   <= 1'b0;
      end
      if (w_done_i) begin
        r_irdata <= memRdata;
      end
      if (w_done_d) begin
        r_drdata <= memRdata;
        r_we     <= 1'b0;
      end
    end
  end

  assign memReq   = (r_state != IDLE);
  assign memWe    = r_we;
  assign memAddr  = r_addr;
  assign memWdata = r_wdata;
  assign iRdata   = r_irdata;
  assign dRdata   = r_drdata;
  assign iReady   = w_done_i;
  assign dReady   = w_done_d;
  assign StallMF  = iReq & ~w_done_i;
  assign StallMM  = dReq & ~w_done_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for the fetch-only, tie, starvation, drop and reset scenarios.
module tb_mem_arbiter;

  localparam int STARVE = 3;

  logic        clk;
  logic        reset_n;
  logic        iReq;
  logic [31:0] iAddr;
  logic [31:0] iRdata;
  logic        iReady;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [31:0] dRdata;
  logic        dReady;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        memAck;
  logic        StallMF;
  logic        StallMM;

  mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(STARVE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .iReq    (iReq),
    .iAddr   (iAddr),
    .iRdata  (iRdata),
    .iReady  (iReady),
    .dReq    (dReq),
    .dWe     (dWe),
    .dAddr   (dAddr),
    .dWdata  (dWdata),
    .dRdata  (dRdata),
    .dReady  (dReady),
    .memReq  (memReq),
    .memWe   (memWe),
    .memAddr (memAddr),
    .memWdata(memWdata),
    .memRdata(memRdata),
    .memAck  (memAck),
    .StallMF (StallMF),
    .StallMM (StallMM)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks in the lat-th cycle memReq is high.
  int          lat      = 1;
  bit          manual   = 1'b0;
  bit          rd_fixed = 1'b0;
  logic [31:0] rd_val   = '0;
  int          lat_cnt  = 0;

  initial begin
    memAck   = 1'b0;
    memRdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!manual) begin
        if (memReq) begin
          lat_cnt++;
          if (lat_cnt >= lat) begin
            memAck   = 1'b1;
            memRdata = rd_fixed ? rd_val : (memAddr ^ 32'hA5A5_0000);
            lat_cnt  = 0;
          end else begin
            memAck = 1'b0;
          end
        end else begin
          memAck  = 1'b0;
          lat_cnt = 0;
        end
      end
    end
  end

  // Transaction model: who owns the port (0 none, 1 fetch, 2 data) and what it latched.
  int          m_own    = 0;
  int          m_starve = 0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wd     = '0;
  logic [31:0] m_ird    = '0;
  logic [31:0] m_drd    = '0;
  logic        m_we     = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_own    <= 0;
      m_starve <= 0;
      m_ird    <= '0;
      m_drd    <= '0;
      m_addr   <= '0;
      m_wd     <= '0;
      m_we     <= 1'b0;
    end else if (m_own == 0) begin
      if (dReq && (!iReq || m_starve < STARVE)) begin
        m_own  <= 2;
        m_addr <= dAddr;
        m_we   <= dWe;
        m_wd   <= dWdata;
        if (iReq) m_starve <= m_starve + 1;
      end else if (iReq) begin
        m_own    <= 1;
        m_addr   <= iAddr;
        m_we     <= 1'b0;
        m_starve <= 0;
      end
    end else if (memAck) begin
      if (m_own == 1) m_ird <= memRdata;
      else m_drd <= memRdata;
      m_own <= 0;
    end
  end

  logic exp_i_done, exp_d_done;
  always @(negedge clk) begin
    exp_i_done = (m_own == 1) && memAck;
    exp_d_done = (m_own == 2) && memAck;
    chk("memReq", memReq, m_own != 0);
    chk("iReady", iReady, exp_i_done);
    chk("dReady", dReady, exp_d_done);
    chk("StallMF", StallMF, iReq && !exp_i_done);
    chk("StallMM", StallMM, dReq && !exp_d_done);
    chk("iRdata", iRdata, m_ird);
    chk("dRdata", dRdata, m_drd);
    chk("starve_cnt", 32'(dut.r_starve_cnt), m_starve);
    if (m_own != 0) begin
      chk("memAddr", memAddr, m_addr);
      chk("memWe", memWe, m_we);
      if (m_own == 2) chk("memWdata", memWdata, m_wd);
    end
  end

  // Grant log: one entry per rising edge of memReq.
  logic [31:0] g_addr[$];
  bit          g_we[$];
  int          g_cyc[$];
  logic        prev_req = 1'b0;
  always @(negedge clk) begin
    if (memReq && !prev_req) begin
      g_addr.push_back(memAddr);
      g_we.push_back(memWe);
      g_cyc.push_back(cyc);
    end
    prev_req <= memReq;
  end

  task automatic clear_log();
    g_addr.delete();
    g_we.delete();
    g_cyc.delete();
  endtask

  int n_req, n_stall, n_rdy;
  bit got, d_done, i_done;

  initial begin
    reset_n = 1'b0;
    dReq    = 1'b0;
    dWe     = 1'b0;
    dAddr   = '0;
    dWdata  = '0;
    // Fetch request already pending during reset: first edge after release must grant it.
    iReq     = 1'b1;
    iAddr    = 32'h40;
    rd_fixed = 1'b1;
    rd_val   = 32'h8C01_0004;
    lat      = 3;
    repeat (3) @(negedge clk);
    chk("rst_memReq", memReq, 0);
    chk("rst_memWe", memWe, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memWdata", memWdata, 0);
    chk("rst_iRdata", iRdata, 0);
    chk("rst_dRdata", dRdata, 0);
    chk("rst_iReady", iReady, 0);
    chk("rst_dReady", dReady, 0);
    #2 reset_n = 1'b1;

    // Fetch only, three-cycle memory.
    n_req = 0; n_stall = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (k == 0) chk("t1_first_grant", memReq, 1);
      if (memReq) begin
        n_req++;
        chk("t1_addr", memAddr, 32'h40);
        chk("t1_we", memWe, 0);
      end
      if (iReady) got = 1;
      else if (StallMF) n_stall++;
    end
    chk("t1_ready_seen", got, 1);
    chk("t1_req_cycles", n_req, 3);
    chk("t1_stall_cycles", n_stall, 2);
    step();
    iReq = 1'b0;
    @(negedge clk);
    chk("t1_irdata", iRdata, 32'h8C01_0004);
    chk("t1_no_regrant", memReq, 0);

    // Simultaneous requests: data first, one idle cycle, then fetch.
    step();
    clear_log();
    rd_fixed = 1'b0;
    lat      = 2;
    iReq = 1'b1; iAddr = 32'h200;
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h100; dWdata = 32'hDEAD;
    d_done = 0; i_done = 0;
    for (int k = 0; k < 40 && !(d_done && i_done); k++) begin
      @(negedge clk);
      if (dReady) d_done = 1;
      if (iReady) i_done = 1;
      step();
      if (d_done) dReq = 1'b0;
      if (i_done) iReq = 1'b0;
    end
    chk("t2_both_done", d_done && i_done, 1);
    chk("t2_grants", g_addr.size(), 2);
    if (g_addr.size() == 2) begin
      chk("t2_first_addr", g_addr[0], 32'h100);
      chk("t2_first_we", g_we[0], 1);
      chk("t2_second_addr", g_addr[1], 32'h200);
      chk("t2_second_we", g_we[1], 0);
      chk("t2_idle_gap", g_cyc[1] - g_cyc[0], 3);
    end
    chk("t2_drdata", dRdata, 32'hA5A5_0100);
    chk("t2_irdata", iRdata, 32'hA5A5_0200);

    // Starvation bound: three data grants, then fetch.
    @(negedge clk);
    step();
    clear_log();
    lat  = 1;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h300;
    iReq = 1'b1; iAddr = 32'h44;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (iReady) got = 1;
    end
    chk("t3_ready_seen", got, 1);
    step();
    dReq = 1'b0;
    iReq = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_starve_clear", 32'(dut.r_starve_cnt), 0);
    chk("t3_grants", g_addr.size(), 4);
    if (g_addr.size() == 4) begin
      chk("t3_g0", g_addr[0], 32'h300);
      chk("t3_g1", g_addr[1], 32'h300);
      chk("t3_g2", g_addr[2], 32'h300);
      chk("t3_g3", g_addr[3], 32'h44);
    end

    // Data request dropped right after its grant still completes once.
    step();
    clear_log();
    lat  = 3;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h500;
    step();
    dReq  = 1'b0;
    n_rdy = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dReady) n_rdy++;
    end
    chk("t4_ready_pulses", n_rdy, 1);
    chk("t4_grants", g_addr.size(), 1);
    chk("t4_drdata", dRdata, 32'hA5A5_0500);

    // Reset during a data access; a late ack must be ignored.
    step();
    manual = 1'b1;
    memAck = 1'b0;
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h600; dWdata = 32'h1234;
    @(negedge clk);
    @(negedge clk);
    chk("t5_in_dacc", memReq, 1);
    #1;
    reset_n = 1'b0;
    dReq    = 1'b0;
    #1;
    chk("t5_req_drop_async", memReq, 0);
    chk("t5_we_drop_async", memWe, 0);
    #1 reset_n = 1'b1;
    step();
    memAck   = 1'b1;
    memRdata = 32'hBEEF;
    @(negedge clk);
    chk("t5_no_dready", dReady, 0);
    chk("t5_no_iready", iReady, 0);
    step();
    memAck = 1'b0;
    @(negedge clk);
    chk("t5_drdata_kept", dRdata, 0);
    chk("t5_idle", memReq, 0);
    manual = 1'b0;

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, meaning the maximum number of consecutive data grants while fetch is waiting.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports iReq in 1 and iAddr in ADDR_W: instruction-fetch read request and address.
REQ-007 SHALL have ports iRdata out DATA_W and iReady out 1: fetch read data and a one-cycle completion pulse.
REQ-008 SHALL have ports dReq in 1, dWe in 1, dAddr in ADDR_W, dWdata in DATA_W: data-stage request, write enable, address and write data.
REQ-009 SHALL have ports dRdata out DATA_W and dReady out 1: data read result and a one-cycle completion pulse.
REQ-010 SHALL have ports memReq out 1, memWe out 1, memAddr out ADDR_W, memWdata out DATA_W: the shared memory request.
REQ-011 SHALL have ports memRdata in DATA_W and memAck in 1: memory read data and a one-cycle completion pulse.
REQ-012 SHALL have ports StallMF out 1 and StallMM out 1: memory-wait stalls to the hazard unit for the fetch and memory stages.

Function
REQ-013 SHALL implement an FSM with states IDLE, IACC (fetch access) and DACC (data access).
REQ-014 In IDLE, SHALL go to DACC if dReq and (!iReq or starve_cnt < STARVE_MAX).
REQ-015 In IDLE, SHALL otherwise go to IACC if iReq, and otherwise stay in IDLE.
REQ-016 On entry to DACC or IACC, SHALL register the granted address; on entry to DACC it SHALL also register dWe and dWdata (a fetch access forces memWe=0).
REQ-017 SHALL drive memReq=1 in IACC and DACC and 0 in IDLE; memAddr, memWe and memWdata SHALL be held stable from the registered copies until memAck.
REQ-018 SHALL tolerate memory latency of 1 or more cycles and SHALL have no timeout; it waits indefinitely for memAck.
REQ-019 SHALL ignore memAck while in IDLE (no output effect).
REQ-020 On memAck in IACC, SHALL assert iReady combinationally in that cycle, capture memRdata into iRdata, and return to IDLE.
REQ-021 On memAck in DACC, SHALL assert dReady combinationally in that cycle, capture memRdata into dRdata (writes too), and return to IDLE.
REQ-022 After every access SHALL spend exactly one cycle in IDLE, so a requester's req still high in its ready cycle is never re-granted.
REQ-023 iRdata and dRdata SHALL hold their value until the next completion for the same requester.
REQ-024 SHALL maintain starve_cnt, $clog2(STARVE_MAX+1) bits wide.
REQ-025 starve_cnt SHALL increment, saturating at STARVE_MAX, on each DACC grant made while iReq=1.
REQ-026 starve_cnt SHALL clear on each IACC grant and SHALL be unchanged otherwise.
REQ-027 StallMF SHALL be iReq & !(IACC & memAck); StallMM SHALL be dReq & !(DACC & memAck); both are combinational.
REQ-028 SHALL drop a request deasserted mid-access without aborting: the access completes and the ready pulse is still issued.

Reset
REQ-029 While reset_n=0, SHALL asynchronously force: state IDLE, starve_cnt 0, memReq 0, memWe 0, memAddr 0, memWdata 0, iRdata 0, dRdata 0, iReady 0, dReady 0.
REQ-030 Reset asserted mid-access SHALL abandon the access immediately, and a later memAck SHALL be ignored.
REQ-031 The first grant SHALL be possible in the first rising edge after reset_n rises.

Structure
REQ-032 Package mips_pkg SHALL hold the arb_state_t enum (IDLE, IACC, DACC) and default ADDR_W/DATA_W constants.
REQ-033 SHALL be a single module with no sub-module; the counter and FSM are inline.

Verification
REQ-034 Fetch only, iReq=1, iAddr=0x40, memAck after 3 cycles with memRdata=0x8C010004 -> memReq held 3 cycles, memAddr=0x40, iReady pulse with iRdata=0x8C010004, StallMF=1 until the ack cycle.
REQ-035 iReq and dReq asserted in the same cycle (dWe=1, dAddr=0x100, dWdata=0xDEAD) -> DACC first with memWe=1, IDLE for one cycle, then IACC.
REQ-036 dReq held high and iReq high, memAck latency 1 -> exactly 3 data grants, then a fetch grant, then starve_cnt=0.
REQ-037 reset_n pulled low during DACC with memAck pending -> memReq=0 the same cycle; memAck arriving afterwards produces no dReady.
REQ-038 dReq dropped in the cycle after the DACC grant -> access still completes and dReady pulses once; no second grant follows.
